// File: rtl/rob_wide.sv
// Reorder buffer with configurable depth, WB_CH write-back channels,
// dual-lane in-order commit and same-cycle write-back bypass on search.
module rob_wide #(
    parameter int ROB_WIDTH = 3,
    parameter int WB_CH     = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        alloc_valid,
    input  logic [1:0]                  alloc_type,
    input  logic [4:0]                  alloc_rd,
    input  logic [31:0]                 alloc_pred,
    input  logic [31:0]                 alloc_val,
    output logic [ROB_WIDTH-1:0]        alloc_id,
    output logic                        full,
    output logic                        empty,
    output logic [ROB_WIDTH:0]          count,
    input  logic [WB_CH-1:0]            wb_valid,
    input  logic [WB_CH*ROB_WIDTH-1:0]  wb_id,
    input  logic [WB_CH*32-1:0]         wb_val,
    input  logic [ROB_WIDTH-1:0]        q_id1,
    input  logic [ROB_WIDTH-1:0]        q_id2,
    output logic                        q_rdy1,
    output logic                        q_rdy2,
    output logic [31:0]                 q_val1,
    output logic [31:0]                 q_val2,
    output logic [1:0]                  cm_valid,
    output logic [2*ROB_WIDTH-1:0]      cm_id,
    output logic [9:0]                  cm_rd,
    output logic [63:0]                 cm_val,
    output logic                        store_commit,
    output logic                        jalr_retire,
    output logic                        flush,
    output logic [31:0]                 flush_pc
);
    localparam int DEPTH = 2**ROB_WIDTH;
    localparam logic [1:0] T_BR   = 2'b00;
    localparam logic [1:0] T_ST   = 2'b01;
    localparam logic [1:0] T_JALR = 2'b10;
    localparam logic [1:0] T_RG   = 2'b11;

    logic [ROB_WIDTH-1:0]    head_q, head_d, tail_q, tail_d, h1;
    logic [ROB_WIDTH:0]      count_q, count_d;
    logic [DEPTH-1:0]        busy_q, busy_d, done_q, done_d;
    logic [DEPTH-1:0][1:0]   type_q, type_d;
    logic [DEPTH-1:0][4:0]   rd_q, rd_d;
    logic [DEPTH-1:0][31:0]  pred_q, pred_d, val_q, val_d;

    logic [1:0]              cm_valid_q, cm_valid_d;
    logic [2*ROB_WIDTH-1:0]  cm_id_q, cm_id_d;
    logic [9:0]              cm_rd_q, cm_rd_d;
    logic [63:0]             cm_val_q, cm_val_d;
    logic                    store_commit_q, store_commit_d;
    logic                    jalr_retire_q, jalr_retire_d;
    logic                    flush_q, flush_d;
    logic [31:0]             flush_pc_q, flush_pc_d;

    logic                    c0, c1, mis, alloc_ok;
    logic [1:0]              t0, t1;

    assign alloc_id     = tail_q;
    assign count        = count_q;
    assign full         = (count_q == (ROB_WIDTH+1)'(DEPTH));
    assign empty        = (count_q == '0);
    assign cm_valid     = cm_valid_q;
    assign cm_id        = cm_id_q;
    assign cm_rd        = cm_rd_q;
    assign cm_val       = cm_val_q;
    assign store_commit = store_commit_q;
    assign jalr_retire  = jalr_retire_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

    // Returns {ready, value}; the highest matching channel overrides the stored value.
    function automatic logic [32:0] search(input logic [ROB_WIDTH-1:0] id);
        logic        hit;
        logic [31:0] v;
        hit = 1'b0;
        v   = val_q[id];
        for (int unsigned k = 0; k < WB_CH; k++) begin
            if (wb_valid[k] && wb_id[k*ROB_WIDTH +: ROB_WIDTH] == id) begin
                hit = 1'b1;
                v   = wb_val[k*32 +: 32];
            end
        end
        return {busy_q[id] && (done_q[id] || hit), v};
    endfunction

    always_comb begin
        {q_rdy1, q_val1} = search(q_id1);
        {q_rdy2, q_val2} = search(q_id2);
    end

    // Commit looks only at registered done bits, so a write-back lands one edge before its commit.
    always_comb begin
        h1       = head_q + ROB_WIDTH'(1);
        t0       = type_q[head_q];
        t1       = type_q[h1];
        c0       = busy_q[head_q] && done_q[head_q];
        mis      = c0 && (t0 == T_BR) && (val_q[head_q] != pred_q[head_q]);
        c1       = c0 && (t0 == T_RG) && busy_q[h1] && done_q[h1] &&
                   ((t1 == T_RG) || (t1 == T_ST));
        alloc_ok = alloc_valid && !full && !flush_q;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;
        type_d  = type_q;
        rd_d    = rd_q;
        pred_d  = pred_q;
        val_d   = val_q;

        cm_valid_d     = '0;
        cm_id_d        = '0;
        cm_rd_d        = '0;
        cm_val_d       = '0;
        store_commit_d = 1'b0;
        jalr_retire_d  = 1'b0;
        flush_d        = 1'b0;
        flush_pc_d     = '0;

        if (flush_q) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
            done_d  = '0;
        end else begin
            for (int unsigned k = 0; k < WB_CH; k++) begin
                if (wb_valid[k] && busy_q[wb_id[k*ROB_WIDTH +: ROB_WIDTH]]) begin
                    done_d[wb_id[k*ROB_WIDTH +: ROB_WIDTH]] = 1'b1;
                    val_d[wb_id[k*ROB_WIDTH +: ROB_WIDTH]]  = wb_val[k*32 +: 32];
                end
            end

            if (c0) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                if ((t0 == T_RG) || (t0 == T_JALR)) begin
                    cm_valid_d[0]            = 1'b1;
                    cm_id_d[ROB_WIDTH-1:0]   = head_q;
                    cm_rd_d[4:0]             = rd_q[head_q];
                    cm_val_d[31:0]           = val_q[head_q];
                end
                store_commit_d = (t0 == T_ST);
                jalr_retire_d  = (t0 == T_JALR);
                flush_d        = mis;
                flush_pc_d     = mis ? val_q[head_q] : '0;
            end

            if (c1) begin
                busy_d[h1] = 1'b0;
                done_d[h1] = 1'b0;
                if (t1 == T_RG) begin
                    cm_valid_d[1]                    = 1'b1;
                    cm_id_d[2*ROB_WIDTH-1:ROB_WIDTH] = h1;
                    cm_rd_d[9:5]                     = rd_q[h1];
                    cm_val_d[63:32]                  = val_q[h1];
                end else begin
                    store_commit_d = 1'b1;
                end
            end

            if (alloc_ok) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                type_d[tail_q] = alloc_type;
                rd_d[tail_q]   = alloc_rd;
                pred_d[tail_q] = alloc_pred;
                val_d[tail_q]  = alloc_val;
                tail_d         = tail_q + ROB_WIDTH'(1);
            end

            head_d  = head_q + ROB_WIDTH'(c0) + ROB_WIDTH'(c1);
            count_d = count_q + (ROB_WIDTH+1)'(alloc_ok)
                              - (ROB_WIDTH+1)'(c0) - (ROB_WIDTH+1)'(c1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            done_q         <= '0;
            type_q         <= '0;
            rd_q           <= '0;
            pred_q         <= '0;
            val_q          <= '0;
            cm_valid_q     <= '0;
            cm_id_q        <= '0;
            cm_rd_q        <= '0;
            cm_val_q       <= '0;
            store_commit_q <= 1'b0;
            jalr_retire_q  <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (rdy_in) begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            type_q         <= type_d;
            rd_q           <= rd_d;
            pred_q         <= pred_d;
            val_q          <= val_d;
            cm_valid_q     <= cm_valid_d;
            cm_id_q        <= cm_id_d;
            cm_rd_q        <= cm_rd_d;
            cm_val_q       <= cm_val_d;
            store_commit_q <= store_commit_d;
            jalr_retire_q  <= jalr_retire_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end
endmodule

// File: tb/tb_rob_wide.sv
// Scoreboard bench for rob_wide: an in-order queue model predicts commit events,
// a separate monitor pops and compares them whenever the DUT presents commit outputs.
module tb_rob_wide;
    localparam int RW    = 3;
    localparam int CH    = 2;
    localparam int DEPTH = 8;
    localparam logic [1:0] BR = 2'b00, ST = 2'b01, JALR = 2'b10, RG = 2'b11;

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in, alloc_valid;
    logic [1:0]      alloc_type;
    logic [4:0]      alloc_rd;
    logic [31:0]     alloc_pred, alloc_val;
    logic [RW-1:0]   alloc_id;
    logic            full, empty;
    logic [RW:0]     count;
    logic [CH-1:0]   wb_valid;
    logic [CH*RW-1:0] wb_id;
    logic [CH*32-1:0] wb_val;
    logic [RW-1:0]   q_id1, q_id2;
    logic            q_rdy1, q_rdy2;
    logic [31:0]     q_val1, q_val2;
    logic [1:0]      cm_valid;
    logic [2*RW-1:0] cm_id;
    logic [9:0]      cm_rd;
    logic [63:0]     cm_val;
    logic            store_commit, jalr_retire, flush;
    logic [31:0]     flush_pc;

    rob_wide #(.ROB_WIDTH(RW), .WB_CH(CH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
        .alloc_pred(alloc_pred), .alloc_val(alloc_val), .alloc_id(alloc_id),
        .full(full), .empty(empty), .count(count),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .q_id1(q_id1), .q_id2(q_id2), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2),
        .q_val1(q_val1), .q_val2(q_val2),
        .cm_valid(cm_valid), .cm_id(cm_id), .cm_rd(cm_rd), .cm_val(cm_val),
        .store_commit(store_commit), .jalr_retire(jalr_retire),
        .flush(flush), .flush_pc(flush_pc)
    );

    initial forever #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pred;
        logic [31:0] val;
        bit          done;
    } ent_t;

    typedef struct packed {
        logic [1:0]  cmv;
        logic [5:0]  id;
        logic [9:0]  rd;
        logic [63:0] val;
        logic        st;
        logic        jr;
        logic        fl;
        logic [31:0] fpc;
    } ev_t;

    ent_t mq[$];
    ev_t  expq[$];
    int   mhead;
    bit   mflush;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int pos(input int id);
        return (id - mhead + DEPTH) % DEPTH;
    endfunction

    // Model of one clock edge, evaluated with the inputs currently driven.
    task automatic model_step();
        int   start, n;
        ev_t  e;
        ent_t x;
        if (!rdy_in) return;
        if (mflush) begin
            mq.delete();
            mhead  = 0;
            mflush = 0;
            return;
        end
        start = mq.size();
        n = 0;
        e = '0;
        if (start > 0 && mq[0].done) begin
            n = 1;
            case (mq[0].typ)
                RG, JALR: begin
                    e.cmv[0]     = 1'b1;
                    e.id[2:0]    = 3'(mhead);
                    e.rd[4:0]    = mq[0].rd;
                    e.val[31:0]  = mq[0].val;
                    e.jr         = (mq[0].typ == JALR);
                end
                ST: e.st = 1'b1;
                default: if (mq[0].val != mq[0].pred) begin
                    e.fl  = 1'b1;
                    e.fpc = mq[0].val;
                end
            endcase
            if (mq[0].typ == RG && start > 1 && mq[1].done &&
                (mq[1].typ == RG || mq[1].typ == ST)) begin
                n = 2;
                if (mq[1].typ == RG) begin
                    e.cmv[1]     = 1'b1;
                    e.id[5:3]    = 3'((mhead + 1) % DEPTH);
                    e.rd[9:5]    = mq[1].rd;
                    e.val[63:32] = mq[1].val;
                end else begin
                    e.st = 1'b1;
                end
            end
        end
        if (e.cmv != 0 || e.st || e.jr || e.fl) expq.push_back(e);
        for (int k = 0; k < CH; k++) begin
            int p;
            p = pos(int'(wb_id[k*RW +: RW]));
            if (wb_valid[k] && p < start) begin
                x = mq[p];
                x.done = 1'b1;
                x.val  = wb_val[k*32 +: 32];
                mq[p]  = x;
            end
        end
        repeat (n) void'(mq.pop_front());
        mhead = (mhead + n) % DEPTH;
        if (alloc_valid && start < DEPTH) begin
            x.typ  = alloc_type;
            x.rd   = alloc_rd;
            x.pred = alloc_pred;
            x.val  = alloc_val;
            x.done = 1'b0;
            mq.push_back(x);
        end
        mflush = e.fl;
    endtask

    task automatic check_search(input logic [RW-1:0] qid, input logic ardy,
                                input logic [31:0] aval, input string nm);
        int          p;
        logic        hit, erdy;
        logic [31:0] bv;
        p   = pos(int'(qid));
        hit = 1'b0;
        bv  = '0;
        for (int k = 0; k < CH; k++) begin
            if (wb_valid[k] && wb_id[k*RW +: RW] == qid) begin
                hit = 1'b1;
                bv  = wb_val[k*32 +: 32];
            end
        end
        erdy = (p < mq.size()) && (hit || mq[p].done);
        chk({nm, "_rdy"}, ardy, erdy);
        if (erdy) chk({nm, "_val"}, aval, hit ? bv : mq[p].val);
    endtask

    task automatic cycle();
        #1;
        check_search(q_id1, q_rdy1, q_val1, "q1");
        check_search(q_id2, q_rdy2, q_val2, "q2");
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("alloc_id", alloc_id, (mhead + mq.size()) % DEPTH);
    endtask

    task automatic set_idle();
        alloc_valid = 1'b0; alloc_type = RG; alloc_rd = '0;
        alloc_pred = '0; alloc_val = '0;
        wb_valid = '0; wb_id = '0; wb_val = '0;
        q_id1 = '0; q_id2 = '0;
    endtask

    task automatic model_clear();
        mq.delete();
        expq.delete();
        mhead  = 0;
        mflush = 0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        set_idle();
        @(negedge clk_in);
        model_clear();
        rst_in = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] rd,
                         input logic [31:0] pred, input logic [31:0] v);
        alloc_valid = 1'b1; alloc_type = t; alloc_rd = rd;
        alloc_pred = pred; alloc_val = v;
        cycle();
        alloc_valid = 1'b0;
    endtask

    task automatic wb2(input logic [1:0] vld, input logic [2:0] id1, input logic [2:0] id0,
                       input logic [31:0] v1, input logic [31:0] v0);
        wb_valid = vld;
        wb_id    = {id1, id0};
        wb_val   = {v1, v0};
        cycle();
        wb_valid = '0;
    endtask

    // Monitor: pops one expectation per enabled edge on which the DUT shows commit activity.
    initial begin
        logic en;
        ev_t  e;
        forever begin
            @(posedge clk_in);
            en = rdy_in && !rst_in;
            #1;
            if (en) begin
                if (cm_valid != 0 || store_commit || jalr_retire || flush) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual cm_valid=%b st=%b jr=%b flush=%b required=none",
                                 cm_valid, store_commit, jalr_retire, flush);
                    end else begin
                        e = expq.pop_front();
                        chk("cm_valid", cm_valid, e.cmv);
                        if (e.cmv[0]) begin
                            chk("cm_id0", cm_id[2:0], e.id[2:0]);
                            chk("cm_rd0", cm_rd[4:0], e.rd[4:0]);
                            chk("cm_val0", cm_val[31:0], e.val[31:0]);
                        end
                        if (e.cmv[1]) begin
                            chk("cm_id1", cm_id[5:3], e.id[5:3]);
                            chk("cm_rd1", cm_rd[9:5], e.rd[9:5]);
                            chk("cm_val1", cm_val[63:32], e.val[63:32]);
                        end
                        chk("store_commit", store_commit, e.st);
                        chk("jalr_retire", jalr_retire, e.jr);
                        chk("flush", flush, e.fl);
                        if (e.fl) chk("flush_pc", flush_pc, e.fpc);
                    end
                end else if (expq.size() != 0) begin
                    e = expq.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_output actual cm_valid=00 st=0 jr=0 flush=0 required cm_valid=%b st=%b jr=%b flush=%b",
                             e.cmv, e.st, e.jr, e.fl);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_cm_valid", cm_valid, 0);
        chk("rst_cm_val", cm_val, 0);
        chk("rst_flush", flush, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_store_commit", store_commit, 0);
        chk("rst_jalr_retire", jalr_retire, 0);

        // Fill to capacity, then an extra alloc must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_alloc_id", alloc_id, i);
            alloc(RG, 5'(i + 1), 32'h0, 32'(i));
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        alloc(RG, 5'd9, 32'h0, 32'h99);
        chk("overfill_count", count, 8);
        chk("overfill_alloc_id", alloc_id, 0);

        // Dual-lane RG commit one edge after write-back.
        wb2(2'b11, 3'd1, 3'd0, 32'h22, 32'h11);
        chk("dual_full_hold", full, 1);
        cycle();
        chk("dual_cm_valid", cm_valid, 2'b11);
        chk("dual_cm_val", cm_val, 64'h0000_0022_0000_0011);
        chk("dual_count", count, 6);

        // Mispredicted branch flushes and discards the younger done RG.
        do_reset();
        alloc(BR, 5'd0, 32'h100, 32'h0);
        alloc(RG, 5'd3, 32'h0, 32'h0);
        wb2(2'b11, 3'd1, 3'd0, 32'h33, 32'h200);
        cycle();
        chk("br_flush", flush, 1);
        chk("br_flush_pc", flush_pc, 32'h200);
        chk("br_cm_valid", cm_valid, 0);
        cycle();
        chk("br_flush_drop", flush, 0);
        chk("br_empty", empty, 1);
        chk("br_cm_valid_after", cm_valid, 0);

        // RG in lane0 and ST in lane1 together.
        do_reset();
        alloc(RG, 5'd7, 32'h0, 32'h0);
        alloc(ST, 5'd0, 32'h0, 32'h0);
        wb2(2'b11, 3'd1, 3'd0, 32'h0, 32'h77);
        cycle();
        chk("st_cm_valid", cm_valid, 2'b01);
        chk("st_store_commit", store_commit, 1);
        chk("st_cm_rd0", cm_rd[4:0], 5'd7);
        chk("st_count", count, 0);

        // Search bypass from a same-cycle write-back.
        do_reset();
        for (int i = 0; i < 4; i++) alloc(RG, 5'(i), 32'h0, 32'hA0 + 32'(i));
        wb_valid = 2'b10;
        wb_id    = {3'd3, 3'd0};
        wb_val   = {32'h55, 32'h0};
        q_id1    = 3'd3;
        #1;
        chk("bypass_q_rdy1", q_rdy1, 1);
        chk("bypass_q_val1", q_val1, 32'h55);
        cycle();
        set_idle();

        // Frozen outputs under rdy_in low, then asynchronous reset mid-cycle.
        do_reset();
        for (int i = 0; i < 3; i++) alloc(RG, 5'(i + 1), 32'h0, 32'h0);
        wb2(2'b11, 3'd1, 3'd0, 32'hB1, 32'hB0);
        cycle();
        chk("ar_cm_valid", cm_valid, 2'b11);
        rdy_in      = 1'b0;
        alloc_valid = 1'b1;
        cycle();
        chk("hold_cm_valid", cm_valid, 2'b11);
        chk("hold_count", count, 1);
        #3;
        rst_in = 1'b1;
        #1;
        chk("async_cm_valid", cm_valid, 0);
        chk("async_cm_val", cm_val, 0);
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_store_commit", store_commit, 0);
        model_clear();
        set_idle();
        @(negedge clk_in);
        rst_in = 1'b0;
        rdy_in = 1'b1;

        // Randomised traffic against the queue model.
        repeat (800) begin
            rdy_in      = ($urandom_range(0, 9) != 0);
            alloc_valid = ($urandom_range(0, 9) < 6);
            alloc_type  = 2'($urandom_range(0, 3));
            alloc_rd    = 5'($urandom);
            alloc_pred  = (alloc_type == BR) ? 32'h100 : $urandom;
            alloc_val   = $urandom;
            for (int k = 0; k < CH; k++) begin
                wb_valid[k] = ($urandom_range(0, 2) != 0);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_id[k*RW +: RW] = RW'((mhead + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
                else
                    wb_id[k*RW +: RW] = RW'($urandom_range(0, DEPTH - 1));
                wb_val[k*32 +: 32] = $urandom_range(0, 1) ? 32'h100 : $urandom;
            end
            q_id1 = $urandom_range(0, 1) ? wb_id[RW-1:0] : RW'($urandom);
            q_id2 = $urandom_range(0, 1) ? wb_id[2*RW-1:RW] : RW'($urandom);
            cycle();
        end
        set_idle();
        rdy_in = 1'b1;
        repeat (4) cycle();
        chk("exp_queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rob_wide.md
Name: rob_wide

Overview:
- Parametrised reorder buffer, successor to the single-retire ROB.
- Sits between decoder/issue, the RS/LSB write-back buses and the regfile.
- Adds configurable depth, WB_CH write-back channels and dual-lane in-order commit.
- Adds occupancy counting with no wasted slot, and search bypass from same-cycle write-back.

Parameters:
- ROB_WIDTH, 3, index width; depth DEPTH = 2**ROB_WIDTH.
- WB_CH, 2, number of write-back channels.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset.
- rdy_in  in  1  global enable; state frozen when low.
- alloc_valid  in  1  decoder issues one entry.
- alloc_type  in  2  BR=00, ST=01, JALR=10, RG=11.
- alloc_rd  in  5  destination register.
- alloc_pred  in  32  predicted target (BR only).
- alloc_val  in  32  initial value.
- alloc_id  out  ROB_WIDTH  tail index.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  ROB_WIDTH+1  occupancy.
- wb_valid  in  WB_CH  per-channel write-back strobe.
- wb_id  in  WB_CH*ROB_WIDTH  entry ids; channel k in slice k.
- wb_val  in  WB_CH*32  result; for BR, the resolved target.
- q_id1, q_id2  in  ROB_WIDTH  search ids.
- q_rdy1, q_rdy2  out  1  entry value available.
- q_val1, q_val2  out  32  entry value.
- cm_valid  out  2  commit lane valid (bit0 = lane0).
- cm_id  out  2*ROB_WIDTH  committed ids.
- cm_rd  out  10  committed rd.
- cm_val  out  64  committed values.
- store_commit  out  1  release head store to LSB.
- jalr_retire  out  1  JALR retired; decoder unfreezes.
- flush  out  1  mispredict, one cycle.
- flush_pc  out  32  correct target.

Behaviour:
- Reset is asynchronous and active-high on rst_in; clk_in is the single clock.
- Reset state:
  - head=tail=0, count=0, all entries not busy/not done.
  - flush=0, flush_pc=0, cm_valid=0, cm_id/cm_rd/cm_val=0.
  - store_commit=0, jalr_retire=0.
- rdy_in low: no state or output changes; registered pulses hold.
- Alloc:
  - Accepted at a clock edge when alloc_valid && !full && !flush && rdy_in.
  - Writes the entry at tail: busy=1, done=0; tail++ wraps mod DEPTH.
  - alloc_valid while full is ignored; the decoder must stall on full.
- Write-back:
  - Channel k with wb_valid[k] and a busy target sets done=1, val=wb_val slice k.
  - Write-back to a non-busy entry is ignored.
  - Multiple channels on the same id in one cycle: highest k wins.
- Search (combinational):
  - q_rdy = busy && (done || any wb_valid[k] with wb_id==q_id).
  - q_val = bypassed wb_val (highest matching k) else the stored val.
- Commit, registered; the entry commits on the edge after it becomes done:
  - Lane0 commits the head if busy && done.
  - Lane1 commits head+1 only if all hold:
    - lane0 commits;
    - the head type is RG;
    - head+1 is busy && done;
    - the head+1 type is RG or ST.
  - BR and JALR retire only in lane0; at most one ST per cycle.
  - RG/JALR: cm_valid bit=1 with id/rd/val; rd=0 still reported (regfile ignores it).
  - ST: store_commit=1 for one cycle; cm_valid bit=0.
  - BR: cm_valid bit=0; if val != pred then flush=1, flush_pc=val, lane1 suppressed.
  - JALR: jalr_retire=1 for one cycle.
  - head advances by the number of committed entries.
- count = count + accepted_alloc - committed, every enabled edge.
- Flush: the edge with flush==1 && rdy_in clears head/tail/count/busy/done, drops alloc, and deasserts flush.
- Simultaneous events:
  - Alloc and commit in the same cycle are both applied; full releases the cycle after commit.
  - Write-back and commit of the same entry in the same cycle: the commit waits one cycle.
- Reset mid-operation aborts immediately; no commit outputs are produced.

Test Plan:
- Reset, then allocate 8 RG entries (ROB_WIDTH=3) -> full=1, count=8, alloc_id wraps 0..7; a 9th alloc is ignored.
- Write back ids 0 and 1 on ch0/ch1 with values 0x11/0x22 -> next edge cm_valid=11, cm_val={0x22,0x11}, count=6.
- BR at head with pred 0x100 and wb 0x200 -> flush=1, flush_pc=0x200 for one cycle; next cycle empty=1 and the younger done RG is not committed.
- ST behind RG, both done -> RG in lane0 and ST in lane1 in the same cycle, store_commit=1, cm_valid=01.
- q_id1=3 while ch1 writes 0x55 to id 3 -> q_rdy1=1, q_val1=0x55 in the same cycle.
- rst_in pulsed asynchronously mid-commit with rdy_in low -> all outputs 0 immediately, count=0.
